// File: rtl/guess_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : guess_game_ctrl
//  Description : Number-guessing game controller. Draws a signed secret from
//                a PRNG sample stream, grades player guesses with
//                higher/lower/correct hints and ends the game in WIN or LOSE
//                once the guess budget is spent.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_game_ctrl #(
    parameter int MAX_TRIES = 7,
    parameter int MAX_MAG   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] prn,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic       guess_ready,
    output logic [7:0] target,
    output logic       higher,
    output logic       lower,
    output logic       correct,
    output logic       bad_guess,
    output logic [3:0] attempts,
    output logic       game_over,
    output logic       won
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DRAW = 3'd1,
        S_PLAY = 3'd2,
        S_WIN  = 3'd3,
        S_LOSE = 3'd4
    } state_t;

    localparam logic signed [7:0] c_mag_pos   = 8'(MAX_MAG);
    localparam logic signed [7:0] c_mag_neg   = -c_mag_pos;
    localparam logic [3:0]        c_max_tries = 4'(MAX_TRIES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic signed [7:0]  r_target;
    logic signed [7:0]  w_target_nxt;
    logic [3:0]         r_attempts;
    logic [3:0]         w_attempts_nxt;
    logic               r_higher;
    logic               w_higher_nxt;
    logic               r_lower;
    logic               w_lower_nxt;
    logic               r_correct;
    logic               w_correct_nxt;
    logic               r_bad;
    logic               w_bad_nxt;

    logic signed [7:0]  w_prn_s;
    logic signed [7:0]  w_guess_s;
    logic               w_prn_ok;
    logic               w_guess_ok;
    logic [3:0]         w_att_inc;

    // Signed views of the raw inputs and their range qualification.
    assign w_prn_s    = signed'(prn);
    assign w_guess_s  = signed'(guess);
    assign w_prn_ok   = (w_prn_s >= c_mag_neg) && (w_prn_s <= c_mag_pos);
    assign w_guess_ok = (w_guess_s >= c_mag_neg) && (w_guess_s <= c_mag_pos);
    assign w_att_inc  = r_attempts + 4'd1;

    // State and game registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_attempts <= '0;
            r_higher   <= 1'b0;
            r_lower    <= 1'b0;
            r_correct  <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_attempts <= w_attempts_nxt;
            r_higher   <= w_higher_nxt;
            r_lower    <= w_lower_nxt;
            r_correct  <= w_correct_nxt;
            r_bad      <= w_bad_nxt;
        end
    end

    // Next-state and next-value logic; every register holds unless changed.
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_attempts_nxt = r_attempts;
        w_higher_nxt   = r_higher;
        w_lower_nxt    = r_lower;
        w_correct_nxt  = r_correct;
        w_bad_nxt      = r_bad;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_DRAW;
                    w_attempts_nxt = '0;
                    w_higher_nxt   = 1'b0;
                    w_lower_nxt    = 1'b0;
                    w_correct_nxt  = 1'b0;
                    w_bad_nxt      = 1'b0;
                end
            end
            S_DRAW: begin
                // Rejection sampling: keep drawing until the sample fits.
                if (w_prn_ok) begin
                    w_target_nxt = w_prn_s;
                    w_state_nxt  = S_PLAY;
                end
            end
            S_PLAY: begin
                // start has priority; a simultaneous guess is dropped.
                if (start) begin
                    w_state_nxt    = S_DRAW;
                    w_attempts_nxt = '0;
                    w_higher_nxt   = 1'b0;
                    w_lower_nxt    = 1'b0;
                    w_correct_nxt  = 1'b0;
                    w_bad_nxt      = 1'b0;
                end else if (guess_valid) begin
                    if (!w_guess_ok) begin
                        // Out-of-range guesses cost nothing and keep hints.
                        w_bad_nxt = 1'b1;
                    end else begin
                        w_attempts_nxt = w_att_inc;
                        w_bad_nxt      = 1'b0;
                        w_higher_nxt   = (w_guess_s < r_target);
                        w_lower_nxt    = (w_guess_s > r_target);
                        w_correct_nxt  = (w_guess_s == r_target);
                        // A correct last guess wins; it is checked first.
                        if (w_guess_s == r_target) begin
                            w_state_nxt = S_WIN;
                        end else if (w_att_inc == c_max_tries) begin
                            w_state_nxt = S_LOSE;
                        end
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    w_state_nxt    = S_DRAW;
                    w_attempts_nxt = '0;
                    w_higher_nxt   = 1'b0;
                    w_lower_nxt    = 1'b0;
                    w_correct_nxt  = 1'b0;
                    w_bad_nxt      = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign guess_ready = (r_state == S_PLAY);
    assign game_over   = (r_state == S_WIN) || (r_state == S_LOSE);
    assign won         = (r_state == S_WIN);
    assign target      = r_target;
    assign attempts    = r_attempts;
    assign higher      = r_higher;
    assign lower       = r_lower;
    assign correct     = r_correct;
    assign bad_guess   = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_game_ctrl
//  Description : Self-checking bench for guess_game_ctrl: directed game
//                scenarios with literal expectations, then randomized play
//                compared every cycle against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_game_ctrl;

    localparam int MAX_TRIES = 7;
    localparam int MAX_MAG   = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] prn = '0;
    logic [7:0] guess = '0;
    logic       guess_valid = 1'b0;
    logic       guess_ready;
    logic [7:0] target;
    logic       higher;
    logic       lower;
    logic       correct;
    logic       bad_guess;
    logic [3:0] attempts;
    logic       game_over;
    logic       won;

    int errors = 0;
    int checks = 0;

    guess_game_ctrl #(.MAX_TRIES(MAX_TRIES), .MAX_MAG(MAX_MAG)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prn         (prn),
        .guess       (guess),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .target      (target),
        .higher      (higher),
        .lower       (lower),
        .correct     (correct),
        .bad_guess   (bad_guess),
        .attempts    (attempts),
        .game_over   (game_over),
        .won         (won)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural game model ----------------
    bit m_draw = 0;
    bit m_play = 0;
    bit m_over = 0;
    bit m_won  = 0;
    int m_target = 0;
    int m_att = 0;
    bit m_hi = 0, m_lo = 0, m_co = 0, m_bad = 0;

    function automatic int sg(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    function automatic bit in_range(input logic [7:0] x);
        return (sg(x) >= -MAX_MAG) && (sg(x) <= MAX_MAG);
    endfunction

    task automatic m_new_game();
        m_draw <= 1; m_play <= 0; m_over <= 0; m_won <= 0;
        m_att <= 0; m_hi <= 0; m_lo <= 0; m_co <= 0; m_bad <= 0;
    endtask

    // Model advances on each clock edge from the rules of the game.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_draw <= 0; m_play <= 0; m_over <= 0; m_won <= 0;
            m_target <= 0; m_att <= 0;
            m_hi <= 0; m_lo <= 0; m_co <= 0; m_bad <= 0;
        end else if (m_draw) begin
            if (in_range(prn)) begin
                m_target <= sg(prn);
                m_draw <= 0;
                m_play <= 1;
            end
        end else if (m_play) begin
            if (start) begin
                m_new_game();
            end else if (guess_valid) begin
                if (!in_range(guess)) begin
                    m_bad <= 1;
                end else begin
                    m_att <= m_att + 1;
                    m_bad <= 0;
                    m_hi  <= sg(guess) < m_target;
                    m_lo  <= sg(guess) > m_target;
                    m_co  <= sg(guess) == m_target;
                    if (sg(guess) == m_target) begin
                        m_play <= 0; m_over <= 1; m_won <= 1;
                    end else if (m_att + 1 == MAX_TRIES) begin
                        m_play <= 0; m_over <= 1; m_won <= 0;
                    end
                end
            end
        end else if (start) begin
            // idle or finished game: only start matters
            m_new_game();
        end
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        logic [18:0] act, exp;
        act = {guess_ready, target, higher, lower, correct, bad_guess,
               attempts, game_over, won};
        exp = {m_play, m_target[7:0], m_hi, m_lo, m_co, m_bad,
               m_att[3:0], m_over, m_over & m_won};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs (caller is at a negedge) and return at the next negedge.
    task automatic drive(input logic st, input logic gv, input logic [7:0] g, input logic [7:0] p);
        start = st; guess_valid = gv; guess = g; prn = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int all_outs();
        return int'({guess_ready, target, higher, lower, correct, bad_guess,
                     attempts, game_over, won});
    endfunction

    initial begin
        logic [7:0] g;
        int r;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b1;

        // Idle ignores guesses and prn until start
        drive(0, 1, 8'd5, 8'h2A);
        drive(0, 1, 8'd5, 8'h2A);
        chk("idle_ready", guess_ready, 0);
        chk("idle_target", sg(target), 0);

        // Draw with rejection: -101, 100 rejected, 42 latched
        drive(1, 0, 8'd0, 8'h9B);
        drive(0, 0, 8'd0, 8'h9B);
        drive(0, 0, 8'd0, 8'h64);
        chk("draw_not_ready", guess_ready, 0);
        drive(0, 0, 8'd0, 8'h2A);
        chk("draw_target", sg(target), 42);
        chk("draw_ready", guess_ready, 1);

        // Guesses 10, 60, 42
        drive(0, 1, 8'd10, 8'h00);
        chk("g10_higher", higher, 1);
        drive(0, 1, 8'd60, 8'h00);
        chk("g60_lower", lower, 1);
        chk("g60_higher_clr", higher, 0);
        drive(0, 1, 8'd42, 8'h00);
        chk("g42_correct", correct, 1);
        chk("g42_attempts", attempts, 3);
        chk("g42_won", won, 1);
        chk("g42_over", game_over, 1);
        drive(0, 1, 8'd1, 8'h00);
        chk("win_hold_attempts", attempts, 3);

        // New game target -5; abort with start+guess in the same cycle
        drive(1, 0, 8'd0, 8'hFB);
        drive(0, 0, 8'd0, 8'hFB);
        chk("t5_target", sg(target), -5);
        drive(0, 1, 8'd0, 8'hFB);
        chk("t5_first_att", attempts, 1);
        drive(1, 1, 8'd0, 8'hFB);
        chk("abort_attempts", attempts, 0);
        chk("abort_ready", guess_ready, 0);
        chk("abort_lower", lower, 0);
        drive(0, 0, 8'd0, 8'hFB);
        chk("abort_redraw", guess_ready, 1);

        // Out-of-range guess keeps hints and attempts
        drive(0, 1, 8'd0, 8'h00);
        drive(0, 1, 8'h80, 8'h00);
        chk("bad_flag", bad_guess, 1);
        chk("bad_attempts", attempts, 1);
        chk("bad_keeps_lower", lower, 1);
        drive(0, 1, 8'd0, 8'h00);
        chk("bad_cleared", bad_guess, 0);
        chk("bad_then_att", attempts, 2);

        // Exhaust the budget with wrong guesses
        repeat (5) drive(0, 1, 8'd0, 8'h00);
        chk("lose_attempts", attempts, 7);
        chk("lose_over", game_over, 1);
        chk("lose_won", won, 0);
        chk("lose_lower", lower, 1);
        drive(0, 1, 8'd0, 8'h00);
        chk("lose_8th_ignored", attempts, 7);

        // Final allowed guess correct wins
        drive(1, 0, 8'd0, 8'h07);
        drive(0, 0, 8'd0, 8'h07);
        repeat (6) drive(0, 1, 8'd1, 8'h00);
        drive(0, 1, 8'd7, 8'h00);
        chk("last_try_won", won, 1);
        chk("last_try_att", attempts, 7);

        // Asynchronous reset mid-game at attempts=3
        drive(1, 0, 8'd0, 8'h2A);
        drive(0, 0, 8'd0, 8'h2A);
        repeat (3) drive(0, 1, 8'd10, 8'h00);
        chk("pre_reset_att", attempts, 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset_outs", all_outs(), 0);
        #4 reset = 1'b1;
        @(negedge clk);
        drive(0, 1, 8'd10, 8'h2A);
        drive(0, 1, 8'd42, 8'h2A);
        chk("post_reset_ready", guess_ready, 0);
        chk("post_reset_att", attempts, 0);

        // Randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      g = 8'($urandom);
            else if (r == 1) g = m_target[7:0];
            else             g = 8'($urandom_range(0, 2 * MAX_MAG) - MAX_MAG);
            drive(($urandom_range(0, 39) == 0), 1'($urandom), g, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 7, meaning the number of valid guesses allowed per game (1..15).
REQ-002 SHALL have parameter MAX_MAG, default 99, meaning the largest magnitude accepted for the target and for guesses.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a new game.
REQ-006 SHALL have port prn, input, 8 bits: two's-complement pseudo-random sample from the PRNG, with a new value every clk.
REQ-007 SHALL have port guess, input, 8 bits: two's-complement player guess.
REQ-008 SHALL have port guess_valid, input, 1 bit: guess is presented this cycle.
REQ-009 SHALL have port guess_ready, output, 1 bit: high only in PLAY.
REQ-010 SHALL have port target, output, 8 bits: latched secret number, two's complement.
REQ-011 SHALL have port higher, output, 1 bit: last accepted guess was below target.
REQ-012 SHALL have port lower, output, 1 bit: last accepted guess was above target.
REQ-013 SHALL have port correct, output, 1 bit: last accepted guess equalled target.
REQ-014 SHALL have port bad_guess, output, 1 bit: last presented guess was outside range.
REQ-015 SHALL have port attempts, output, 4 bits: count of valid guesses in the current game.
REQ-016 SHALL have port game_over, output, 1 bit: high in WIN or LOSE.
REQ-017 SHALL have port won, output, 1 bit: high in WIN only.

Function
REQ-018 SHALL implement states IDLE, DRAW, PLAY, WIN and LOSE.
REQ-019 IDLE SHALL go to DRAW on start; all other inputs are ignored.
REQ-020 DRAW SHALL treat prn as signed each cycle; if -MAX_MAG <= prn <= MAX_MAG it SHALL latch target=prn and go to PLAY the next cycle, otherwise stay in DRAW.
REQ-021 On entry to DRAW, attempts, higher, lower, correct and bad_guess SHALL clear to 0.
REQ-022 In PLAY with guess_valid high and guess outside +/-MAX_MAG, the block SHALL set bad_guess=1 for that guess, leave attempts unchanged and keep the previous hint flags.
REQ-023 In PLAY with guess_valid high and guess in range, the block SHALL increment attempts, clear bad_guess, and set exactly one of higher, lower or correct from a signed compare.
REQ-024 All flags SHALL update one clock after the accepting edge and hold until the next accepted guess or a new game.
REQ-025 An in-range guess equal to target SHALL cause a transition to WIN.
REQ-026 An in-range wrong guess that makes attempts equal MAX_TRIES SHALL cause a transition to LOSE.
REQ-027 If the final allowed guess is also correct, the result SHALL be WIN, not LOSE.
REQ-028 A start in PLAY SHALL abort the game and go to DRAW; start SHALL win over a simultaneous guess_valid, and that guess is discarded.
REQ-029 In WIN and LOSE, target, attempts and flags SHALL hold, guess_valid SHALL be ignored, and start SHALL go to DRAW.
REQ-030 All comparisons SHALL be 8-bit signed; attempts SHALL never exceed MAX_TRIES and never wrap.

Reset
REQ-031 reset low SHALL immediately force IDLE and set target=0, attempts=0, and guess_ready, higher, lower, correct, bad_guess, game_over and won all to 0, regardless of the clock.
REQ-032 Reset asserted mid-game SHALL discard the game.
REQ-033 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-034 Scenario: start, then prn sequence 8'h9B (-101), 8'h64 (100), 8'h2A (42) -> two cycles in DRAW, target=42, guess_ready=1.
REQ-035 Scenario: target=42, then guesses 10, 60, 42 -> higher, lower, correct in turn; attempts=3; won=1; game_over=1.
REQ-036 Scenario: target=-5, then seven guesses of 0 -> lower=1 each time; attempts=7; LOSE (game_over=1, won=0); an eighth guess is ignored.
REQ-037 Scenario: in PLAY, guess=8'h80 (-128) -> bad_guess=1, attempts unchanged; next guess in range clears bad_guess.
REQ-038 Scenario: in PLAY, start and guess_valid in the same cycle -> DRAW, attempts=0, the guess has no effect.
REQ-039 Scenario: reset pulsed low between clock edges in PLAY with attempts=3 -> outputs go to their reset values without waiting for a clock edge, state is IDLE, and guesses are ignored until start.
